// File: rtl/ysquare_pkg.sv
// Shared types for the uio bus arbiter: FSM states, owner identity and bus width.
package ysquare_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    OWN
  } state_e;

  typedef enum logic {
    OWNER_A,
    OWNER_B
  } owner_e;

  function automatic owner_e other_of(input owner_e o);
    return (o == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to whoever
// was not served last. Purely combinational.
module rr_arb2 (
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_b_i,
  output logic valid_o,
  output logic pick_b_o
);

  assign valid_o  = req_a_i | req_b_i;
  assign pick_b_o = req_b_i & (~req_a_i | ~last_b_i);

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbitrates two byte-wide requesters onto a shared bidirectional uio pad bus,
// inserting a turnaround gap with the pads released between owners.
module uio_bus_arbiter
  import ysquare_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [BUS_W-1:0] data_a,
  input  logic             req_b,
  input  logic [BUS_W-1:0] data_b,
  input  logic [BUS_W-1:0] uio_in,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [BUS_W-1:0] uio_out,
  output logic [BUS_W-1:0] uio_oe,
  output logic [BUS_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [7:0]       burst_q, burst_d;
  logic [3:0]       turn_q, turn_d;
  logic [BUS_W-1:0] rx_data_q;
  logic             rx_valid_q, rx_valid_d;

  logic pick_valid, pick_b;
  logic owner_req, other_req;

  rr_arb2 u_rr_arb2 (
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .last_b_i (last_q == OWNER_B),
    .valid_o  (pick_valid),
    .pick_b_o (pick_b)
  );

  assign owner_req = (owner_q == OWNER_A) ? req_a : req_b;
  assign other_req = (owner_q == OWNER_A) ? req_b : req_a;

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    turn_d  = turn_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = TURN;
          owner_d = pick_b ? OWNER_B : OWNER_A;
          turn_d  = '0;
        end
      end

      TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d = '0;
          // A requester that gave up during turnaround forfeits the bus.
          if (owner_req) begin
            state_d = OWN;
            burst_d = 8'd1;
            last_d  = owner_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end

      OWN: begin
        if (!owner_req) begin
          if (other_req) begin
            state_d = TURN;
            owner_d = other_of(owner_q);
            turn_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (burst_q == BURST_MAX) begin
          // Burst limit only forces a handover when someone else is waiting.
          if (other_req) begin
            state_d = TURN;
            owner_d = other_of(owner_q);
            turn_d  = '0;
          end else begin
            burst_d = 8'd1;
          end
        end else begin
          burst_d = burst_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_valid_d = (state_d == IDLE) && (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_A;
      last_q     <= OWNER_B;
      burst_q    <= '0;
      turn_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      turn_q     <= turn_d;
      rx_data_q  <= uio_in;
      rx_valid_q <= rx_valid_d;
    end
  end

  logic in_own;
  assign in_own = (state_q == OWN);

  assign gnt_a    = in_own && (owner_q == OWNER_A);
  assign gnt_b    = in_own && (owner_q == OWNER_B);
  assign uio_oe   = in_own ? {BUS_W{1'b1}} : {BUS_W{1'b0}};
  assign uio_out  = !in_own ? {BUS_W{1'b0}} : (owner_q == OWNER_A) ? data_a : data_b;
  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter with TURN_CYCLES=2, MAX_BURST=4.
module tb_uio_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b, uio_in;
  logic       gnt_a, gnt_b;
  logic [7:0] uio_out, uio_oe, rx_data;
  logic       rx_valid, busy;

  int errors = 0;
  int checks = 0;

  uio_bus_arbiter #(
    .TURN_CYCLES (2),
    .MAX_BURST   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .uio_in   (uio_in),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    uio_in = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    uio_in = 8'h5A;
    step();
    checks++;
    if ({gnt_a, gnt_b, uio_oe, uio_out} !== 18'h0) begin
      errors++;
      $display("FAIL reset_bus: gnt_a=%b gnt_b=%b oe=%h out=%h, want all zero", gnt_a, gnt_b, uio_oe, uio_out);
    end
    checks++;
    if ({rx_data, rx_valid, busy} !== 10'h0) begin
      errors++;
      $display("FAIL reset_rx: rx_data=%h rx_valid=%b busy=%b, want 00/0/0", rx_data, rx_valid, busy);
    end
    rst    = 1'b0;
    uio_in = 8'h00;
  endtask

  task automatic test_single_grant();
    do_reset();
    req_a  = 1'b1;
    data_a = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({busy, gnt_a, gnt_b, uio_oe} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL single_turn%0d: busy=%b gnt_a=%b gnt_b=%b oe=%h, want 1/0/0/00", k, busy, gnt_a, gnt_b, uio_oe);
      end
    end
    step();
    checks++;
    if ({gnt_a, gnt_b, uio_oe, uio_out} !== {1'b1, 1'b0, 8'hFF, 8'hA5}) begin
      errors++;
      $display("FAIL single_own: gnt_a=%b gnt_b=%b oe=%h out=%h, want 1/0/FF/A5", gnt_a, gnt_b, uio_oe, uio_out);
    end
    data_a = 8'h5A;
    #1;
    checks++;
    if (uio_out !== 8'h5A) begin
      errors++;
      $display("FAIL single_comb_data: out=%h, want 5A", uio_out);
    end
    req_a = 1'b0;
    step();
    checks++;
    if ({busy, gnt_a, uio_oe} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_release: busy=%b gnt_a=%b oe=%h, want 0/0/00", busy, gnt_a, uio_oe);
    end
  endtask

  task automatic test_rx();
    uio_in = 8'h3C;
    step();
    checks++;
    if ({rx_data, rx_valid} !== {8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL rx_idle: rx_data=%h rx_valid=%b, want 3C/1", rx_data, rx_valid);
    end
    req_a = 1'b1;
    step();
    step();
    step();
    uio_in = 8'hC3;
    step();
    checks++;
    if ({gnt_a, rx_data, rx_valid} !== {1'b1, 8'hC3, 1'b0}) begin
      errors++;
      $display("FAIL rx_own: gnt_a=%b rx_data=%h rx_valid=%b, want 1/C3/0", gnt_a, rx_data, rx_valid);
    end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic        exp_ga, exp_gb;
    logic [17:0] exp_v;
    int          p;
    do_reset();
    data_a = 8'h11;
    data_b = 8'h22;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      p      = (k - 1) % 12;
      exp_ga = (p >= 2) && (p <= 5);
      exp_gb = (p >= 8);
      exp_v  = {exp_ga, exp_gb, (exp_ga | exp_gb) ? 8'hFF : 8'h00,
                exp_ga ? 8'h11 : (exp_gb ? 8'h22 : 8'h00)};
      checks++;
      if ({gnt_a, gnt_b, uio_oe, uio_out} !== exp_v) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt_a=%b gnt_b=%b oe=%h out=%h, want %b/%b/%h/%h",
                 k, gnt_a, gnt_b, uio_oe, uio_out, exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_long_burst();
    do_reset();
    req_a  = 1'b1;
    data_a = 8'h77;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, uio_oe, uio_out} !== {1'b1, 1'b0, 8'hFF, 8'h77}) begin
        errors++;
        $display("FAIL burst_cycle%0d: gnt_a=%b gnt_b=%b oe=%h out=%h, want 1/0/FF/77", k, gnt_a, gnt_b, uio_oe, uio_out);
      end
    end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_handoff();
    do_reset();
    data_a = 8'h11;
    data_b = 8'h22;
    req_a  = 1'b1;
    step();
    step();
    step();
    req_a = 1'b0;
    req_b = 1'b1;
    step();
    checks++;
    if ({busy, gnt_a, gnt_b, uio_oe} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL handoff_turn: busy=%b gnt_a=%b gnt_b=%b oe=%h, want 1/0/0/00", busy, gnt_a, gnt_b, uio_oe);
    end
    step();
    step();
    checks++;
    if ({gnt_a, gnt_b, uio_oe, uio_out} !== {1'b0, 1'b1, 8'hFF, 8'h22}) begin
      errors++;
      $display("FAIL handoff_own_b: gnt_a=%b gnt_b=%b oe=%h out=%h, want 0/1/FF/22", gnt_a, gnt_b, uio_oe, uio_out);
    end
    req_b = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    data_a = 8'h11;
    data_b = 8'h22;
    req_b  = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({gnt_b, uio_oe} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL midown_pre: gnt_b=%b oe=%h, want 1/FF", gnt_b, uio_oe);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({gnt_a, gnt_b, uio_oe, uio_out, busy} !== 19'h0) begin
      errors++;
      $display("FAIL midown_reset: gnt_a=%b gnt_b=%b oe=%h out=%h busy=%b, want all zero", gnt_a, gnt_b, uio_oe, uio_out, busy);
    end
    rst   = 1'b0;
    req_a = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({gnt_a, gnt_b, uio_out} !== {1'b1, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL midown_tie_a: gnt_a=%b gnt_b=%b out=%h, want 1/0/11", gnt_a, gnt_b, uio_out);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  task automatic test_abort_turn();
    do_reset();
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, uio_oe} !== {1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL abort_cycle%0d: gnt_a=%b gnt_b=%b oe=%h, want 0/0/00", k, gnt_a, gnt_b, uio_oe);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rx();
    test_round_robin();
    test_long_burst();
    test_handoff();
    test_reset_mid_own();
    test_abort_turn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter: TURN_CYCLES, default 2, bus-turnaround cycles with uio_oe=0 before any new owner drives (legal 1..15).
REQ-002 Parameter: MAX_BURST, default 16, maximum OWN cycles before arbitration is re-run (legal 1..255).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_a  in  1  requester A wants to drive the uio pins.
REQ-006 data_a  in  8  byte driven by A while granted.
REQ-007 req_b  in  1  requester B wants to drive the uio pins.
REQ-008 data_b  in  8  byte driven by B while granted.
REQ-009 uio_in  in  8  pad input path.
REQ-010 gnt_a / gnt_b  out  1 each  ownership grants.
REQ-011 uio_out  out  8  pad output path.
REQ-012 uio_oe  out  8  pad output enable, active high.
REQ-013 rx_data  out  8  registered uio_in.
REQ-014 rx_valid  out  1  rx_data was captured while the bus was released.
REQ-015 busy  out  1  high in TURN or OWN.

Function
REQ-016 FSM states: IDLE, TURN, OWN; owner register (A/B); last-served register (A/B).
REQ-017 IDLE: uio_oe=8'h00, gnt_a=gnt_b=0, uio_out=8'h00.
REQ-018 IDLE with any req at edge E: pick owner round-robin (sole requester wins; both requesting -> the one not last served); TURN occupies TURN_CYCLES cycles; OWN is entered at edge E+TURN_CYCLES.
REQ-019 TURN: uio_oe=8'h00, no grant; on final TURN cycle, if the pending owner's req is low, go to IDLE, not OWN.
REQ-020 OWN: gnt of owner=1, uio_oe=8'hFF, uio_out=owner's data combinationally (zero latency); last-served updates to owner.
REQ-021 Burst counter: counts OWN cycles from 1; clears on OWN entry.
REQ-022 OWN exit: owner's req low -> other req high ? TURN to other : IDLE (uio_oe drops on that edge).
REQ-023 Counter reaches MAX_BURST with owner req still high: other requesting -> TURN to other; else counter clears and OWN continues with no uio_oe gap.
REQ-024 Invariants: gnt_a&gnt_b never 1; uio_oe only 8'h00 or 8'hFF; uio_oe=8'hFF exactly when a gnt is 1.
REQ-025 rx_data <= uio_in every edge; rx_valid <= (next state is IDLE and state is IDLE).
REQ-026 busy = (state != IDLE), combinational.

Reset
REQ-027 rst high at an edge: state IDLE, counter 0, last-served=B (A wins first tie), rx_data=8'h00, rx_valid=0; thus gnt=0, uio_oe=8'h00, uio_out=8'h00 after that edge, including mid-OWN or mid-TURN.

Structure
REQ-028 Shared package ysquare_pkg holds the state enum (IDLE/TURN/OWN), owner enum (A/B), and bus width constant 8.
REQ-029 One sub-module rr_arb2: 2-way round-robin pick from req_a, req_b, last-served; combinational.

Verification (TURN_CYCLES=2, MAX_BURST=4)
REQ-030 Reset, then req_a=1, data_a=8'hA5 sampled at edge E -> gnt_a=1, uio_oe=8'hFF, uio_out=8'hA5 after edge E+2, low for E+0..E+1.
REQ-031 req_a=req_b=1 held from reset release -> A owns 4 cycles, 2 cycles uio_oe=8'h00, B owns 4, repeats; never both grants.
REQ-032 req_a held alone 20 cycles -> gnt_a continuous after turnaround, no uio_oe gap at burst boundaries.
REQ-033 IDLE, uio_in=8'h3C -> next cycle rx_data=8'h3C, rx_valid=1; rx_valid=0 during OWN.
REQ-034 rst pulsed mid-OWN of B -> after that edge gnt_b=0, uio_oe=8'h00; then both req -> A granted first.
REQ-035 req_a pulses for 1 cycle into TURN -> returns to IDLE, gnt_a never asserted, uio_oe stays 8'h00.
